softmax_ce_grad: RTL
====================

Name: softmax_ce_grad

Overview:
- Loss/gradient stage directly downstream of dense_layer in the training path.
- Consumes the dense layer's forward logits (N rows × CHAR_NUM) and one target character index per row.
- Computes row-wise softmax and produces the cross-entropy gradient softmax − onehot(label).
- The gradient is sized and formatted to drive dense_layer's backward input directly; it uses the same run/valid handshake as the rest of the train path.

Parameters:
- N, `N, rows (characters per sample).
- CHAR_NUM, `CHAR_NUM, columns (vocabulary size).
- HID_DIM is not used.
- N_LEN, `N_LEN, logit element width (signed fixed point).
- N_LEN_W, `N_LEN_W, gradient element width (signed fixed point).
- F, `N_F, fractional bits of both formats.
- LBL_W, $clog2(CHAR_NUM)+1, label field width.
- BATCH_SHIFT, $clog2(`BATCH_SIZE), gradient shift used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start request; held high until valid seen, then dropped.
- d_forward  in  N*CHAR_NUM*N_LEN  logits; element (r,j) at bits [(r*CHAR_NUM+j)*N_LEN +: N_LEN].
- d_label  in  N*LBL_W  target index per row.
- valid  out  1  gradient complete.
- q_backward  out  N*CHAR_NUM*N_LEN_W  gradient, same packing as d_forward.

Behaviour:
- Reset (async, any state): FSM→IDLE, valid=0, q_backward=0, all counters and buffers cleared.
- Sampling: d_forward and d_label are sampled in IDLE on the first cycle run=1. Later input changes are ignored until the next run.
- FSM, processed one row r at a time, one column j per cycle:
  - IDLE: on run=1 → MAX.
  - MAX: CHAR_NUM cycles; m = max over j of x[r][j] (signed).
  - EXP: CHAR_NUM cycles; z = x − m (≤0).
    - t = z·LOG2E, where LOG2E = round(1.4427·2^F).
    - k = floor(t), f = frac(t).
    - e = (2^F + f·2^F) >> (−k), unsigned F+1 bits; e = 0 when −k > F.
    - e is stored in the row buffer; sum += e. The sum register is F+1+$clog2(CHAR_NUM) bits and cannot overflow.
  - RECIP: exactly F+2 cycles; restoring divider computes R = floor(2^(2F)/sum). sum ≥ 2^F always (max element gives e = 2^F), so R ≤ 2^F.
  - NORM: CHAR_NUM cycles.
    - p = (e·R) >> F.
    - g = p − (j==label ? 2^F : 0).
    - g is saturated to signed N_LEN_W and written to q_backward element (r,j).
  - ROWNEXT: 1 cycle; r++. If r == N → DONE, else → MAX.
  - DONE: valid=1; hold until run=0, then valid=0 and → IDLE (same cycle).
- Latency: valid is high exactly N·(3·CHAR_NUM + F + 3) + 1 cycles after the clock edge that samples run=1 in IDLE.
- Outputs:
  - q_backward elements may change during NORM. They are stable and valid from valid rise until the next run.
  - q_backward holds its last value in IDLE.
- run dropped before DONE: abort; → IDLE next edge; valid stays 0; q_backward contents undefined until the next completed run.
- Label ≥ CHAR_NUM (padding row): no onehot subtraction; g = p.
- Max tie: any maximal element gives an identical result.
- Rounding: all right shifts truncate toward −∞. No rounding is performed except in LOG2E.

Optional Feature:
- Macro: GRAD_BATCH_SCALE_EN.
- Defined: g is arithmetic-shifted right by BATCH_SHIFT with round-half-up before saturation (mean-over-batch gradient).
- Undefined: no scaling; BATCH_SHIFT is unused and latency is unchanged.

Test Plan:
- All logits 0, all labels 0, run held → valid at the specified latency.
  - Every p = floor(2^F/CHAR_NUM) ±1 LSB.
  - g[r][0] = p − 2^F; other g = p.
- Row 0: logit[0][5] = +8.0, others 0, label 5 → g[0][5] ∈ [−2,0] LSB; others ∈ [0,1] LSB.
- Label = CHAR_NUM for all rows, random logits → all g ≥ 0; each row sums to 2^F within ±CHAR_NUM LSB.
- run dropped 3 cycles into the first EXP → valid never rises; FSM in IDLE next cycle. A rerun with the same data gives a bit-identical q_backward vs. a clean run.
- rst_n pulsed low mid-NORM → valid=0 and q_backward=0 immediately (asynchronous). A rerun completes at the normal latency.
- With GRAD_BATCH_SCALE_EN and BATCH_SHIFT=2, scenario 1 data → every g equals the unscaled value >>2 with round-half-up (compare to a golden model).

Source files
------------

// File: rtl/softmax_ce_grad.sv
// softmax_ce_grad: row-wise softmax of dense_layer logits minus onehot(label), one column per cycle.
// Optional macro GRAD_BATCH_SCALE_EN: gradient arithmetic-shifted by BATCH_SHIFT (round-half-up) before saturation.
module softmax_ce_grad #(
  parameter int N        = 2,
  parameter int CHAR_NUM = 8,
  parameter int N_LEN    = 16,
  parameter int N_LEN_W  = 16,
  parameter int F        = 8,
  parameter int LBL_W    = $clog2(CHAR_NUM) + 1
`ifdef GRAD_BATCH_SCALE_EN
  ,
  parameter int BATCH_SHIFT = 2
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]     d_forward,
  input  logic [N*LBL_W-1:0]              d_label,
  output logic                            valid,
  output logic [N*CHAR_NUM*N_LEN_W-1:0]   q_backward
);

  localparam int CW    = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = $clog2(F + 3);
  localparam int SHW   = $clog2(F + 1);
  localparam int SW    = F + 1 + $clog2(CHAR_NUM);
  localparam int DW    = SW + F + 1;
  localparam int ZW    = N_LEN + 1;
  localparam int PW    = ZW + F + 2;
  localparam int GW    = F + 3;
  localparam int SX    = ((GW > N_LEN_W) ? GW : N_LEN_W) + 1;
  localparam int LOG2E = (14427 * (1 << F) + 5000) / 10000;

  localparam logic signed [PW-1:0] F_S    = PW'(F);
  localparam logic signed [GW-1:0] ONE_F  = GW'(1 << F);
  localparam logic signed [SX-1:0] SAT_HI = SX'((64'sd1 <<< (N_LEN_W - 1)) - 64'sd1);
  localparam logic signed [SX-1:0] SAT_LO = -SAT_HI - SX'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAX, S_EXP, S_RECIP, S_NORM, S_ROWNEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N*CHAR_NUM*N_LEN-1:0] x_r;
  logic [N*LBL_W-1:0]          lbl_r;
  logic [RW-1:0]               r;
  logic [CW-1:0]               j;
  logic [KW-1:0]               rcnt;
  logic signed [N_LEN-1:0]     m;
  logic [SW-1:0]               sum;
  logic [DW-1:0]               rem, dvs;
  logic [F:0]                  rq;
  logic [F:0]                  e_buf [CHAR_NUM];

  int                          elem;
  logic signed [N_LEN-1:0]     x_cur;
  logic [LBL_W-1:0]            lbl_cur;
  logic signed [ZW-1:0]        z;
  logic signed [PW-1:0]        prod, t, k, nk;
  logic [F:0]                  mant, e_cur;
  logic [2*F+1:0]              er;
  logic [F+1:0]                p;
  logic                        hit;
  logic signed [GW-1:0]        g;
  logic signed [N_LEN_W-1:0]   g_out;

  function automatic logic signed [N_LEN_W-1:0] sat(input logic signed [GW-1:0] v);
    logic signed [SX-1:0] w;
    w = SX'(v);
    if (w > SAT_HI) return N_LEN_W'(SAT_HI);
    if (w < SAT_LO) return N_LEN_W'(SAT_LO);
    return N_LEN_W'(w);
  endfunction

`ifdef GRAD_BATCH_SCALE_EN
  function automatic logic signed [GW-1:0] rnd_shift(input logic signed [GW-1:0] v);
    logic signed [GW:0] w;
    w = (GW+1)'(v) + (GW+1)'(1 << (BATCH_SHIFT - 1));
    return GW'(w >>> BATCH_SHIFT);
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_MAX;
      S_MAX:     if (!run) state_nxt = S_IDLE;
                 else if (j == CW'(CHAR_NUM - 1)) state_nxt = S_EXP;
      S_EXP:     if (!run) state_nxt = S_IDLE;
                 else if (j == CW'(CHAR_NUM - 1)) state_nxt = S_RECIP;
      S_RECIP:   if (!run) state_nxt = S_IDLE;
                 else if (rcnt == KW'(F + 1)) state_nxt = S_NORM;
      S_NORM:    if (!run) state_nxt = S_IDLE;
                 else if (j == CW'(CHAR_NUM - 1)) state_nxt = S_ROWNEXT;
      S_ROWNEXT: if (!run) state_nxt = S_IDLE;
                 else if (r == RW'(N - 1)) state_nxt = S_DONE;
                 else state_nxt = S_MAX;
      S_DONE:    if (!run) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // exp stage: e = (1 + frac) >> -floor(t), linear approximation of 2^t
  always_comb begin
    elem    = int'(r) * CHAR_NUM + int'(j);
    x_cur   = x_r[elem * N_LEN +: N_LEN];
    lbl_cur = lbl_r[int'(r) * LBL_W +: LBL_W];
    z       = {x_cur[N_LEN-1], x_cur} - {m[N_LEN-1], m};
    prod    = PW'(z) * PW'(LOG2E);
    t       = prod >>> F;
    k       = t >>> F;
    nk      = -k;
    mant    = {1'b1, t[F-1:0]};
    e_cur   = '0;
    if (nk <= F_S) e_cur = mant >> nk[SHW-1:0];
  end

  // norm stage: p = e*R >> F, subtract onehot, optional batch scaling, saturate
  always_comb begin
    er  = (2*F+2)'(e_buf[j]) * (2*F+2)'(rq);
    p   = (F+2)'(er >> F);
    hit = (lbl_cur == LBL_W'(j));
    g   = $signed({1'b0, p});
    if (hit) g = g - ONE_F;
`ifdef GRAD_BATCH_SCALE_EN
    g_out = sat(rnd_shift(g));
`else
    g_out = sat(g);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      q_backward <= '0;
      x_r        <= '0;
      lbl_r      <= '0;
      r          <= '0;
      j          <= '0;
      rcnt       <= '0;
      m          <= '0;
      sum        <= '0;
      rem        <= '0;
      dvs        <= '0;
      rq         <= '0;
      for (int i = 0; i < CHAR_NUM; i++) e_buf[i] <= '0;
    end else begin
      valid <= (state == S_DONE) && run;
      j     <= (state_nxt == state && (state == S_MAX || state == S_EXP || state == S_NORM))
               ? j + CW'(1) : '0;
      rcnt  <= (state == S_RECIP && state_nxt == S_RECIP) ? rcnt + KW'(1) : '0;
      case (state)
        S_IDLE: if (run) begin
          x_r   <= d_forward;
          lbl_r <= d_label;
          r     <= '0;
        end
        S_MAX: if (j == '0 || x_cur > m) m <= x_cur;
        S_EXP: begin
          e_buf[j] <= e_cur;
          sum      <= ((j == '0) ? '0 : sum) + SW'(e_cur);
        end
        // restoring divider: first cycle loads, then one quotient bit per cycle, MSB first
        S_RECIP: if (rcnt == '0) begin
          rem <= DW'(1) << (2 * F);
          dvs <= DW'(sum) << F;
          rq  <= '0;
        end else begin
          if (rem >= dvs) begin
            rem <= rem - dvs;
            rq  <= {rq[F-1:0], 1'b1};
          end else begin
            rq  <= {rq[F-1:0], 1'b0};
          end
          dvs <= dvs >> 1;
        end
        S_NORM:    q_backward[elem * N_LEN_W +: N_LEN_W] <= g_out;
        S_ROWNEXT: r <= r + RW'(1);
        default: ;
      endcase
    end
  end

endmodule
